// File: rtl/ibex_trace_buffer_if.sv
// RVFI capture bus plus valid/ready readout port of the trace buffer.
// master drives retirements and consumes records; slave is the buffer.
interface ibex_trace_buffer_if;
  logic        rvfi_valid;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic        rvfi_trap;
  logic        rvfi_intr;

  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [31:0] rd_pc_o;
  logic [31:0] rd_insn_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic [1:0]  rd_flags_o;

  modport master (
    output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_trap, rvfi_intr, rd_ready_i,
    input  rd_valid_o, rd_pc_o, rd_insn_o, rd_addr_o, rd_wdata_o, rd_flags_o
  );

  modport slave (
    input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_trap, rvfi_intr, rd_ready_i,
    output rd_valid_o, rd_pc_o, rd_insn_o, rd_addr_o, rd_wdata_o, rd_flags_o
  );
endinterface

// File: rtl/ibex_trace_buffer.sv
// Circular RVFI trace store (fill-stop / wrap / PC-trigger), FWFT readout; 1-cycle push-to-visible.
// Capture never stalls the core: a full buffer drops (fill-stop) or overwrites (wrap/trigger).
module ibex_trace_buffer #(
  parameter int unsigned Depth           = 16,
  parameter int unsigned PostTrigDefault = 4,
  parameter int unsigned DropCntWidth    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  ibex_trace_buffer_if.slave        bus,
  input  logic [1:0]                mode_i,
  input  logic                      arm_i,
  input  logic                      clear_i,
  input  logic [31:0]               trig_pc_i,
  input  logic [$clog2(Depth):0]    trig_post_i,
  output logic [$clog2(Depth):0]    count_o,
  output logic [DropCntWidth-1:0]   dropped_o,
  output logic                      triggered_o,
  output logic                      frozen_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StPost    = 2'd2;
  localparam logic [1:0] StFrozen  = 2'd3;

  localparam logic [1:0] ModeOff  = 2'd0;
  localparam logic [1:0] ModeFill = 2'd1;
  localparam logic [1:0] ModeTrig = 2'd3;

  localparam logic [CW-1:0]           DepthC   = CW'(Depth);
  localparam logic [CW-1:0]           PostDefC = CW'(PostTrigDefault);
  localparam logic [CW-1:0]           CntOne   = CW'(1);
  localparam logic [AW-1:0]           PtrOne   = AW'(1);
  localparam logic [DropCntWidth-1:0] DropOne  = DropCntWidth'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  flags;
  } rec_t;

  rec_t mem [Depth];
  rec_t rec_in;
  rec_t head;

  logic [1:0]              state_q;
  logic [1:0]              mode_q;
  logic [31:0]             trig_pc_q;
  logic [CW-1:0]           post_q;
  logic [CW-1:0]           rem_q;
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [DropCntWidth-1:0] dropped_q;
  logic                    triggered_q;

  logic          ctrl;
  logic          empty;
  logic          full;
  logic          capture;
  logic          pop;
  logic          discard;
  logic          push;
  logic          overwrite;
  logic          trig_hit;
  logic [CW-1:0] post_sel;

  assign rec_in = '{pc:    bus.rvfi_pc_rdata,
                    insn:  bus.rvfi_insn,
                    addr:  bus.rvfi_rd_addr,
                    wdata: bus.rvfi_rd_wdata,
                    flags: {bus.rvfi_trap, bus.rvfi_intr}};

  // arm/clear take the whole cycle: no capture and no pop alongside them
  assign ctrl      = clear_i | arm_i;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthC);
  assign capture   = bus.rvfi_valid & ((state_q == StCapture) | (state_q == StPost)) & ~ctrl;
  assign pop       = ~empty & bus.rd_ready_i & ~ctrl;
  assign discard   = capture & full & ~pop & (mode_q == ModeFill);
  assign push      = capture & ~discard;
  assign overwrite = push & full & ~pop;
  assign trig_hit  = push & (state_q == StCapture) & (mode_q == ModeTrig) &
                     (bus.rvfi_pc_rdata == trig_pc_q);

  always_comb begin
    post_sel = trig_post_i;
    if (trig_post_i == '0) begin
      post_sel = PostDefC;
    end else if (trig_post_i > DepthC) begin
      post_sel = DepthC;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mode_q      <= ModeOff;
      trig_pc_q   <= '0;
      post_q      <= '0;
      rem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dropped_q   <= '0;
      triggered_q <= 1'b0;
    end else if (clear_i) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dropped_q   <= '0;
      triggered_q <= 1'b0;
    end else if (arm_i) begin
      state_q     <= (mode_i == ModeOff) ? StIdle : StCapture;
      mode_q      <= mode_i;
      trig_pc_q   <= trig_pc_i;
      post_q      <= post_sel;
      rem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dropped_q   <= '0;
      triggered_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      // an overwrite retires the oldest record, so the head moves with the tail
      if (pop || overwrite) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (push && !pop && !full) begin
        count_q <= count_q + CntOne;
      end else if (pop && !push) begin
        count_q <= count_q - CntOne;
      end
      if ((discard || overwrite) && (dropped_q != '1)) begin
        dropped_q <= dropped_q + DropOne;
      end
      if (trig_hit) begin
        triggered_q <= 1'b1;
      end
      if (discard) begin
        state_q <= StFrozen;
      end else if (trig_hit) begin
        rem_q   <= post_q;
        state_q <= (post_q == '0) ? StFrozen : StPost;
      end else if (push && (state_q == StPost)) begin
        rem_q <= rem_q - CntOne;
        if (rem_q == CntOne) begin
          state_q <= StFrozen;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= rec_in;
    end
  end

  assign head = mem[rd_ptr_q];

  assign bus.rd_valid_o = ~empty;
  assign bus.rd_pc_o    = empty ? '0 : head.pc;
  assign bus.rd_insn_o  = empty ? '0 : head.insn;
  assign bus.rd_addr_o  = empty ? '0 : head.addr;
  assign bus.rd_wdata_o = empty ? '0 : head.wdata;
  assign bus.rd_flags_o = empty ? '0 : head.flags;

  assign count_o     = count_q;
  assign dropped_o   = dropped_q;
  assign triggered_o = triggered_q;
  assign frozen_o    = (state_q == StFrozen);
endmodule
